// File: rtl/cond_pkg.sv
// Shared types for the execute-stage conditional-execution controller.
// Optional feature macro used by this slice: COND_UNDEF_TRAP_EN.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic       reg_write;
    logic       mem_write;
    logic       pc_src;
  } e_ctrl_t;

  localparam e_ctrl_t E_BUBBLE = '0;

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } exec_state_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition-field decode against the current NZCV flags.
// COND_UNDEF_TRAP_EN makes cond=1111 report undef instead of silently never passing.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       undef
);

  logic n, z, c, v, ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    pass  = 1'b0;
    undef = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~(c & ~z);
      GE: pass = ge;
      LT: pass = ~ge;
      GT: pass = ~z & ge;
      LE: pass = ~(~z & ge);
      AL: pass = 1'b1;
      NV: begin
        // NV never passes; with the trap build it additionally flags the slot.
        pass = 1'b0;
`ifdef COND_UNDEF_TRAP_EN
        undef = 1'b1;
`else
        undef = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// E-stage control register, NZCV register and branch squash FSM for the ARM pipeline.
// Honours COND_UNDEF_TRAP_EN through cond_eval (undef_e stays 0 when the macro is undefined).
module cond_exec_ctrl
  import cond_pkg::*;
#(
  parameter int SQUASH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic [3:0] cond_d,
  input  logic [1:0] flag_write_d,
  input  logic       reg_write_d,
  input  logic       mem_write_d,
  input  logic       pc_src_d,
  input  logic [3:0] alu_flags_e,
  output logic       reg_write_e,
  output logic       mem_write_e,
  output logic       pc_src_e,
  output logic       cond_ex_e,
  output logic       flush_fd,
  output logic [3:0] flags_q,
  output logic       undef_e
);

  localparam logic [2:0] SQUASH_LOAD =
    (SQUASH_CYCLES > 0) ? 3'(SQUASH_CYCLES - 1) : 3'd0;

  e_ctrl_t     e_q, e_d;
  logic [3:0]  flags_d;
  exec_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cond_pass, cond_undef, active;

  cond_eval u_cond_eval (
    .cond  (e_q.cond),
    .flags (flags_q),
    .pass  (cond_pass),
    .undef (cond_undef)
  );

  // A stalled or empty slot must have no side effects at all.
  assign active      = e_q.valid & ~stall_e;
  assign cond_ex_e   = active & cond_pass;
  assign undef_e     = active & cond_undef;
  assign reg_write_e = e_q.reg_write & cond_ex_e;
  assign mem_write_e = e_q.mem_write & cond_ex_e;
  assign pc_src_e    = e_q.pc_src & cond_ex_e;
  assign flush_fd    = pc_src_e;

  always_comb begin
    e_d = e_q;
    if (flush_e || state_q == ST_SQUASH) begin
      e_d = E_BUBBLE;
    end else if (!stall_e) begin
      e_d.valid      = 1'b1;
      e_d.cond       = cond_d;
      e_d.flag_write = flag_write_d;
      e_d.reg_write  = reg_write_d;
      e_d.mem_write  = mem_write_d;
      e_d.pc_src     = pc_src_d;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (cond_ex_e) begin
      if (e_q.flag_write[1]) begin
        flags_d[FLAG_N] = alu_flags_e[FLAG_N];
        flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
      end
      if (e_q.flag_write[0]) begin
        flags_d[FLAG_C] = alu_flags_e[FLAG_C];
        flags_d[FLAG_V] = alu_flags_e[FLAG_V];
      end
    end
  end

  // Squash length counts unstalled cycles so a stall cannot shorten the bubble train.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (pc_src_e && (SQUASH_CYCLES > 0)) begin
          state_d = ST_SQUASH;
          cnt_d   = SQUASH_LOAD;
        end
      end
      ST_SQUASH: begin
        if (!stall_e) begin
          if (cnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= E_BUBBLE;
      flags_q <= 4'b0000;
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      e_q     <= e_d;
      flags_q <= flags_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed and randomized bench for cond_exec_ctrl with a behavioural pipeline model.
// Build with COND_UNDEF_TRAP_EN defined to expect the undef trap pulse.
module tb_cond_exec_ctrl;

  localparam int SQ = 2;
`ifdef COND_UNDEF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_e;
  logic       flush_e;
  logic [3:0] cond_d;
  logic [1:0] flag_write_d;
  logic       reg_write_d;
  logic       mem_write_d;
  logic       pc_src_d;
  logic [3:0] alu_flags_e;
  logic       reg_write_e;
  logic       mem_write_e;
  logic       pc_src_e;
  logic       cond_ex_e;
  logic       flush_fd;
  logic [3:0] flags_q;
  logic       undef_e;

  int errors = 0;
  int checks = 0;

  // Reference model: what instruction sits in E, the flags, and how many squash cycles remain.
  bit         mValid;
  logic [3:0] mCond;
  logic [1:0] mFw;
  bit         mRw, mMw, mPc;
  logic [3:0] mFlags;
  int         squashLeft;

  cond_exec_ctrl #(.SQUASH_CYCLES(SQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_e      (stall_e),
    .flush_e      (flush_e),
    .cond_d       (cond_d),
    .flag_write_d (flag_write_d),
    .reg_write_d  (reg_write_d),
    .mem_write_d  (mem_write_d),
    .pc_src_d     (pc_src_d),
    .alu_flags_e  (alu_flags_e),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .pc_src_e     (pc_src_e),
    .cond_ex_e    (cond_ex_e),
    .flush_fd     (flush_fd),
    .flags_q      (flags_q),
    .undef_e      (undef_e)
  );

  always #5 clk = ~clk;

  function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, ge;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    ge = (n == v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return ge;
      4'd11: return !ge;
      4'd12: return !z && ge;
      4'd13: return !(!z && ge);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit cx, ud;
    cx = mValid && !stall_e && condHolds(mCond, mFlags);
    ud = TRAP && mValid && !stall_e && (mCond == 4'hF);
    check("cond_ex_e",   {3'b0, cond_ex_e},   {3'b0, cx});
    check("reg_write_e", {3'b0, reg_write_e}, {3'b0, cx && mRw});
    check("mem_write_e", {3'b0, mem_write_e}, {3'b0, cx && mMw});
    check("pc_src_e",    {3'b0, pc_src_e},    {3'b0, cx && mPc});
    check("flush_fd",    {3'b0, flush_fd},    {3'b0, cx && mPc});
    check("undef_e",     {3'b0, undef_e},     {3'b0, ud});
    check("flags_q",     flags_q,             mFlags);
  endtask

  task automatic stepModel();
    bit cx, taken;
    cx    = mValid && !stall_e && condHolds(mCond, mFlags);
    taken = cx && mPc;
    if (reset) begin
      {mValid, mCond, mFw, mRw, mMw, mPc} = '0;
      mFlags     = 4'b0000;
      squashLeft = 0;
      return;
    end
    if (cx) begin
      if (mFw[1]) mFlags[3:2] = alu_flags_e[3:2];
      if (mFw[0]) mFlags[1:0] = alu_flags_e[1:0];
    end
    if (flush_e || squashLeft > 0) begin
      {mValid, mCond, mFw, mRw, mMw, mPc} = '0;
    end else if (!stall_e) begin
      mValid = 1'b1;
      mCond  = cond_d;
      mFw    = flag_write_d;
      mRw    = reg_write_d;
      mMw    = mem_write_d;
      mPc    = pc_src_d;
    end
    if (squashLeft > 0) begin
      if (!stall_e) squashLeft--;
    end else if (taken) begin
      squashLeft = SQ;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [1:0] fw, input logic rw,
                               input logic mw, input logic pc, input logic [3:0] alu,
                               input logic st, input logic fl);
    cond_d       = c;
    flag_write_d = fw;
    reg_write_d  = rw;
    mem_write_d  = mw;
    pc_src_d     = pc;
    alu_flags_e  = alu;
    stall_e      = st;
    flush_e      = fl;
  endtask

  task automatic cycle();
    #2;
    checkOutput();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic applyRandom();
    applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0));
  endtask

  initial begin
    // Reset held for two cycles with random D-side traffic.
    reset = 1'b1;
    applyRandom();
    @(posedge clk);
    stepModel();
    #1;
    applyRandom();
    cycle();
    reset = 1'b0;
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    #1;
    check("rst_flags", flags_q, 4'b0000);
    check("rst_outs", {reg_write_e, mem_write_e, pc_src_e, cond_ex_e}, 4'b0000);
    check("rst_flush_undef", {2'b00, flush_fd, undef_e}, 4'b0000);
    cycle();

    // CMP sets Z, BEQ is taken.
    applyStimulus(4'hE, 2'b11, 0, 0, 0, 4'h0, 0, 0);
    cycle();
    applyStimulus(4'h0, 2'b00, 0, 0, 1, 4'b0100, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    #1;
    check("chain_flags", flags_q, 4'b0100);
    check("chain_pc_src", {3'b0, pc_src_e}, 4'b0001);
    check("chain_flush_fd", {3'b0, flush_fd}, 4'b0001);
    cycle();

    // Squash train: stores presented during SQUASH never reach E; the third one executes.
    applyStimulus(4'hE, 2'b00, 0, 1, 0, 4'h0, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 1, 0, 4'h0, 0, 0);
    #1;
    check("squash_slot1_mem", {3'b0, mem_write_e}, 4'b0000);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 1, 0, 4'h0, 0, 0);
    #1;
    check("squash_slot2_mem", {3'b0, mem_write_e}, 4'b0000);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    #1;
    check("squash_third_mem", {3'b0, mem_write_e}, 4'b0001);
    cycle();

    // CMP clears Z, BEQ not taken.
    applyStimulus(4'hE, 2'b11, 0, 0, 0, 4'h0, 0, 0);
    cycle();
    applyStimulus(4'h0, 2'b00, 0, 0, 1, 4'b0000, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    #1;
    check("nochain_flags", flags_q, 4'b0000);
    check("nochain_pc_src", {3'b0, pc_src_e}, 4'b0000);
    check("nochain_flush_fd", {3'b0, flush_fd}, 4'b0000);
    cycle();

    // Partial update: only N,Z written.
    applyStimulus(4'hE, 2'b11, 0, 0, 0, 4'h0, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b10, 0, 0, 0, 4'b1111, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
    cycle();
    check("partial_flags", flags_q, 4'b0011);
    applyStimulus(4'hE, 2'b11, 0, 0, 0, 4'h0, 0, 0);
    cycle();
    applyStimulus(4'h1, 2'b10, 0, 0, 0, 4'b1111, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
    #1;
    check("failcond_cond_ex", {3'b0, cond_ex_e}, 4'b0000);
    cycle();
    check("failcond_flags", flags_q, 4'b1111);

    // ADDS held by a 3-cycle stall, then exactly one flag update.
    applyStimulus(4'hE, 2'b11, 1, 0, 0, 4'h0, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'b1010, 1, 0);
      #1;
      check("stall_reg_write", {3'b0, reg_write_e}, 4'b0000);
      check("stall_flags", flags_q, 4'b1111);
      cycle();
    end
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'b1010, 0, 0);
    #1;
    check("release_reg_write", {3'b0, reg_write_e}, 4'b0001);
    cycle();
    check("release_flags", flags_q, 4'b1010);
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'b0101, 0, 0);
    cycle();
    check("single_update_flags", flags_q, 4'b1010);

    // flush_e wins over stall_e.
    applyStimulus(4'hE, 2'b11, 1, 0, 0, 4'h0, 1, 1);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    #1;
    check("flush_stall_cond_ex", {3'b0, cond_ex_e}, 4'b0000);
    check("flush_stall_reg_write", {3'b0, reg_write_e}, 4'b0000);
    cycle();

    // Undefined condition.
    applyStimulus(4'hF, 2'b00, 1, 0, 0, 4'h0, 0, 0);
    cycle();
    applyStimulus(4'hE, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    #1;
    check("undef_reg_write", {3'b0, reg_write_e}, 4'b0000);
    check("undef_pulse", {3'b0, undef_e}, {3'b0, TRAP});
    cycle();

    // Randomized traffic against the model, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      applyRandom();
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
